// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined integer add/subtract unit with valid/ready handshakes.
//
// The WIDTH-bit carry chain is cut into STAGES slices of WIDTH/STAGES bits.
// Slice k is added in stage k, using the carry registered by stage k-1. Operand
// bits that are still to be added travel down in skew registers. Finished sum
// bits travel down in de-skew registers. The last stage computes the flags and
// holds the output registers.
//
// Parameters:
//   WIDTH   operand/result width; must be a multiple of STAGES
//   STAGES  pipeline depth, 1..8
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset; drops every in-flight beat
//   in_valid_i   operand beat present
//   in_ready_o   beat accepted this cycle (= pipeline advances)
//   in_a_i       operand A
//   in_b_i       operand B
//   in_op_i      [0]: 0 add, 1 sub (A-B); [1]: signed saturate (ADDER_SAT_EN only)
//   out_valid_o  result beat present
//   out_ready_i  downstream takes the result
//   out_sum_o    result (modulo 2^WIDTH, or clamped when saturating)
//   out_carry_o  carry-out of the top slice; for sub, 1 iff A >= B unsigned
//   out_ovf_o    signed overflow of the unsaturated result
//   out_zero_o   out_sum_o == 0, after saturation
//
// Optional feature macro: ADDER_SAT_EN
//   defined   -> in_op_i[1] = 1 clamps signed overflow to the signed min/max
//   undefined -> in_op_i[1] is ignored and results always wrap

module pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_a_i,
  input  logic [WIDTH-1:0] in_b_i,
  input  logic [1:0]       in_op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_sum_o,
  output logic             out_carry_o,
  output logic             out_ovf_o,
  output logic             out_zero_o
);

  localparam int unsigned SliceW = WIDTH / STAGES;

  // The whole pipeline moves as one unit; it only freezes when the output
  // stage holds a result nobody takes.
  logic advance;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_carry_q;
  logic             out_ovf_q;
  logic             out_zero_q;

  assign advance    = out_ready_i | ~out_valid_q;
  assign in_ready_o = advance;

  assign out_valid_o = out_valid_q;
  assign out_sum_o   = out_sum_q;
  assign out_carry_o = out_carry_q;
  assign out_ovf_o   = out_ovf_q;
  assign out_zero_o  = out_zero_q;

`ifndef ADDER_SAT_EN
  // Without saturation the mode bit has no function.
  logic unused_op;
  assign unused_op = in_op_i[1];
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned Lo = k * SliceW;   // first bit of this slice
    localparam int unsigned Hi = Lo + SliceW;  // one past the last bit

    // Operand bits [WIDTH-1:Lo]; the low SliceW of them are added here.
    logic [WIDTH-Lo-1:0] a_cur;
    logic [WIDTH-Lo-1:0] b_cur;
    logic                cin;
    logic                valid_cur;
    logic [Hi-1:0]       sum_cur;
    logic [SliceW:0]     slice_res;
`ifdef ADDER_SAT_EN
    logic                sat_cur;
`endif

    assign slice_res = {1'b0, a_cur[SliceW-1:0]} + {1'b0, b_cur[SliceW-1:0]}
                     + {{SliceW{1'b0}}, cin};

    // ---------------------------------------------------------------------
    // Stage inputs: straight from the ports for slice 0, else from stage k-1
    // ---------------------------------------------------------------------
    if (k == 0) begin : g_head
      // Subtract is A + ~B + 1: invert B and feed the op bit in as carry.
      assign a_cur     = in_a_i;
      assign b_cur     = in_b_i ^ {WIDTH{in_op_i[0]}};
      assign cin       = in_op_i[0];
      assign valid_cur = in_valid_i;
      assign sum_cur   = slice_res[SliceW-1:0];
`ifdef ADDER_SAT_EN
      assign sat_cur   = in_op_i[1];
`endif
    end else begin : g_body
      assign a_cur     = g_stage[k-1].g_mid.a_q;
      assign b_cur     = g_stage[k-1].g_mid.b_q;
      assign cin       = g_stage[k-1].g_mid.carry_q;
      assign valid_cur = g_stage[k-1].g_mid.valid_q;
      assign sum_cur   = {slice_res[SliceW-1:0], g_stage[k-1].g_mid.sum_q};
`ifdef ADDER_SAT_EN
      assign sat_cur   = g_stage[k-1].g_mid.sat_q;
`endif
    end

    // ---------------------------------------------------------------------
    // Stage registers: intermediate skew/de-skew, or the output stage
    // ---------------------------------------------------------------------
    if (k < STAGES - 1) begin : g_mid
      logic                valid_q;
      logic                carry_q;
      logic [WIDTH-Hi-1:0] a_q;
      logic [WIDTH-Hi-1:0] b_q;
      logic [Hi-1:0]       sum_q;
`ifdef ADDER_SAT_EN
      logic                sat_q;
`endif

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          valid_q <= 1'b0;
        end else if (advance) begin
          valid_q <= valid_cur;
        end
      end

      // Data only moves with a real beat; bubbles leave it untouched.
      always_ff @(posedge clk_i) begin
        if (advance && valid_cur) begin
          carry_q <= slice_res[SliceW];
          a_q     <= a_cur[WIDTH-Lo-1:SliceW];
          b_q     <= b_cur[WIDTH-Lo-1:SliceW];
          sum_q   <= sum_cur;
`ifdef ADDER_SAT_EN
          sat_q   <= sat_cur;
`endif
        end
      end
    end else begin : g_tail
      logic             a_msb;
      logic             b_msb;
      logic             ovf;
      logic [WIDTH-1:0] res;

      // b_msb is the MSB of the possibly inverted B, so one rule covers both ops.
      assign a_msb = a_cur[WIDTH-Lo-1];
      assign b_msb = b_cur[WIDTH-Lo-1];
      assign ovf   = (a_msb == b_msb) && (sum_cur[WIDTH-1] != a_msb);

      always_comb begin
        res = sum_cur;
`ifdef ADDER_SAT_EN
        // Overflow direction follows the sign of A (both operands share it).
        if (sat_cur && ovf) begin
          res = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          out_valid_q <= 1'b0;
          out_sum_q   <= '0;
          out_carry_q <= 1'b0;
          out_ovf_q   <= 1'b0;
          out_zero_q  <= 1'b0;
        end else if (advance) begin
          out_valid_q <= valid_cur;
          if (valid_cur) begin
            out_sum_q   <= res;
            out_carry_q <= slice_res[SliceW];
            out_ovf_q   <= ovf;
            out_zero_q  <= ~|res;
          end
        end
      end
    end
  end

endmodule

// File: doc/pipe_addsub.md
# pipe_addsub

Parametrised, pipelined integer add/subtract unit for the RISC-V datapath. It is the registered successor to the single-cycle 32-bit adder, with several changes:
- operand width and pipeline depth are configurable;
- a subtract mode is added;
- it produces carry, overflow and zero flags;
- it uses valid/ready handshakes on both sides.

It sits between the operand-forwarding muxes and writeback, for use where a full-width carry chain does not close timing in one cycle.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of STAGES.
- STAGES, 2: pipeline depth, 1..8. The carry chain is split into STAGES slices of WIDTH/STAGES bits each.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  bit0: 0 = add, 1 = sub (A−B). bit1: signed saturate, effective only with ADDER_SAT_EN.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result.
- out_carry  out  1  unsigned carry-out. For sub this is the no-borrow bit (1 iff A ≥ B unsigned).
- out_ovf  out  1  signed overflow of the unsaturated result.
- out_zero  out  1  out_sum == 0, evaluated after saturation.

## Operation
- Subtract is computed as A + ~B + 1: carry-in of slice 0 = in_op[0].
- Slice k (bits k·S .. k·S+S−1, with S = WIDTH/STAGES) is added in pipeline stage k, using the registered carry from stage k−1.
  - Operand bits above slice k are carried forward in skew registers.
  - Result bits of completed slices are carried forward in de-skew registers.
  - All slices of one beat emerge together at the last stage.
- Flags are computed in the final stage:
  - carry = carry-out of the top slice.
  - ovf = (A_msb == B'_msb) && (sum_msb != A_msb), where B' is the inverted B for sub.
  - zero = ~|out_sum.
- Each stage holds one valid bit plus its data. No bubble collapsing: the pipeline advances as a unit.
- advance = out_ready || !out_valid. in_ready = advance.
  - An input beat is accepted iff in_valid && in_ready.
  - When advance = 0, every stage register, the valid bits and all outputs hold.
- The output registers are the final stage. out_* stay stable while out_valid && !out_ready.
- Arithmetic is modulo 2^WIDTH. Operands are treated as both signed and unsigned; the flags cover both interpretations.

## Timing
- Latency: a beat accepted at edge n appears on out_valid/out_sum after edge n+STAGES−1. STAGES = 1 means the result is registered one edge after accept.
- Throughput: one beat per cycle with out_ready held high.
- Reset, sampled at a rising edge:
  - all valid bits clear, so out_valid = 0;
  - out_sum = 0, out_carry = 0, out_ovf = 0, out_zero = 0;
  - in_ready = 1 from the first cycle after reset.
- Reset mid-operation discards every in-flight beat; no partial result is ever presented.
- Accept and retire in the same cycle when full: the stalled output is consumed and a new beat enters on the same edge, with no lost or duplicated beats.
- Backpressure propagates combinationally: in_ready depends on out_ready in the same cycle.

## Configuration
- ADDER_SAT_EN defined: when in_op[1] = 1 and signed overflow occurs, out_sum clamps.
  - Positive overflow gives 2^(WIDTH−1)−1; negative overflow gives −2^(WIDTH−1).
  - out_ovf still reports 1, and out_zero is evaluated on the clamped value.
  - The clamp mux is in the final stage and adds no latency.
- ADDER_SAT_EN undefined: in_op[1] is ignored, results always wrap, and no saturation logic is generated.

## Test plan
All scenarios use WIDTH = 32, STAGES = 4.

- Reset, then add A = 0x0000_FFFF, B = 0x0000_0001 with out_ready = 1 → out_valid rises 3 edges after accept; sum = 0x0001_0000, carry = 0, ovf = 0, zero = 0. This checks carry crossing a slice boundary.
- Sub A = 5, B = 5 → sum = 0, zero = 1, carry = 1. Then sub A = 3, B = 5 → sum = 0xFFFF_FFFE, carry = 0.
- Add A = 0x7FFF_FFFF, B = 1:
  - op = 00 → sum = 0x8000_0000, ovf = 1.
  - op = 10 with ADDER_SAT_EN → sum = 0x7FFF_FFFF, ovf = 1.
  - op = 10 without the macro → sum = 0x8000_0000.
- Stream 8 back-to-back beats (A = i, B = 0xFFFF_FFFF) while out_ready toggles 1,0,0,1,…:
  - results are i−1 with carry = 1 for i ≥ 1, in order, no loss or duplication;
  - out_* are stable during stalls;
  - in_ready tracks advance every cycle.
- Fill the pipeline with 4 beats, then assert reset for 1 cycle → out_valid = 0 and out_sum = 0 next cycle; none of the 4 beats ever appears.
- Add A = 0xFFFF_FFFF, B = 1 → sum = 0, carry = 1, zero = 1, ovf = 0.
